// File: rtl/mem_scan_reader.sv
// Streams a contiguous range of BRAM words through port B into a small output FIFO.
// Optional build macro SCAN_LOOP_EN repeats the scan for as long as start is held high.
module mem_scan_reader #(
  parameter int FIFO_DEPTH = 4  // power of two, >= 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] base_addr,
  input  logic [15:0] count,
  output logic [15:0] addr_b,
  output logic        we_b,
  output logic [15:0] data_b,
  input  logic [15:0] q_b,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_e;

  state_e             state_q, state_d;
  logic [15:0]        addr_q, addr_d;
  logic [15:0]        remaining_q, remaining_d;
  logic               inflight_q, inflight_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   fcnt_q, fcnt_d;
  logic [15:0]        fifo_mem [FIFO_DEPTH];
`ifdef SCAN_LOOP_EN
  logic [15:0]        base_q, base_d;
  logic [15:0]        len_q, len_d;
`endif

  logic               push;
  logic               pop;
  logic               issue;
  logic [CNT_W-1:0]   free_slots;

  // The word requested last cycle is on q_b now, so the in-flight flag doubles as the push strobe.
  assign push       = inflight_q;
  assign pop        = (fcnt_q != '0) && out_ready;
  assign free_slots = CNT_W'(FIFO_DEPTH) - fcnt_q;
  assign issue      = (state_q == READ) && (remaining_q != '0) &&
                      (free_slots > CNT_W'(inflight_q));

  // NOTE: every signal assigned in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    inflight_d  = issue;
`ifdef SCAN_LOOP_EN
    base_d      = base_q;
    len_d       = len_q;
`endif

    if (issue) begin
      addr_d      = addr_q + 16'd1;
      remaining_d = remaining_q - 16'd1;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
`ifdef SCAN_LOOP_EN
          base_d = base_addr;
          len_d  = count;
`endif
          if (count == '0) begin
            state_d = DONE;
          end else begin
            state_d     = READ;
            addr_d      = base_addr;
            remaining_d = count;
          end
        end
      end
      READ: begin
        if (issue && (remaining_q == 16'd1)) state_d = DRAIN;
      end
      DRAIN: begin
        if ((fcnt_q == '0) && !inflight_q) state_d = DONE;
      end
      DONE: begin
`ifdef SCAN_LOOP_EN
        if (start && (len_q != '0)) begin
          state_d     = READ;
          addr_d      = base_q;
          remaining_d = len_q;
        end else if (!start) begin
          state_d = IDLE;
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // Push and pop in the same cycle cancel in the occupancy count.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fcnt_d   = fcnt_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   fcnt_d = fcnt_q + CNT_W'(1);
      2'b01:   fcnt_d = fcnt_q - CNT_W'(1);
      default: fcnt_d = fcnt_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      inflight_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fcnt_q      <= '0;
`ifdef SCAN_LOOP_EN
      base_q      <= '0;
      len_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      inflight_q  <= inflight_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fcnt_q      <= fcnt_d;
`ifdef SCAN_LOOP_EN
      base_q      <= base_d;
      len_q       <= len_d;
`endif
    end
  end

  // NOTE: FIFO storage has no reset; the pointers and count define validity, and this keeps it mappable to RAM.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= q_b;
  end

  assign addr_b    = addr_q;
  assign we_b      = 1'b0;
  assign data_b    = 16'h0000;
  assign out_valid = (fcnt_q != '0);
  assign out_data  = out_valid ? fifo_mem[rd_ptr_q] : 16'h0000;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_mem_scan_reader.sv
// Self-checking bench for mem_scan_reader: BRAM model, expected-word queue per scan,
// directed and random scans, back-pressure, address wrap, zero count and mid-scan reset.
module tb_mem_scan_reader;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] base_addr = '0;
  logic [15:0] count = '0;
  logic [15:0] q_b;
  logic [15:0] addr_b, data_b, out_data;
  logic        we_b, out_valid, busy, done;

  mem_scan_reader #(.FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .count     (count),
    .addr_b    (addr_b),
    .we_b      (we_b),
    .data_b    (data_b),
    .q_b       (q_b),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Synchronous-read BRAM: data for the address presented before an edge appears after it.
  logic [15:0] mem_model [65536];
  always_ff @(posedge clk) q_b <= mem_model[addr_b];

  int          n_assert = 0;
  int          n_fail   = 0;
  int          edge_n   = 0;
  logic [15:0] exp_q [$];
  logic [15:0] addr_log [$];
  logic [15:0] last_addr = '0;
  int          done_cnt, done_edge, first_valid_edge, first_word_edge, last_word_edge;
  int          words, acc_edge, passes;
  bit          we_bad = 1'b0;
  bit          loop_mode = 1'b0;
  logic [15:0] cur_base, cur_len;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called just before a rising edge: what is seen here is what that edge acts on.
  task automatic observe();
    if (we_b !== 1'b0 || data_b !== 16'h0000) we_bad = 1'b1;
    if (addr_b !== last_addr) begin
      addr_log.push_back(addr_b);
      last_addr = addr_b;
    end
    if (out_valid === 1'b1 && first_valid_edge < 0) first_valid_edge = edge_n;
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) check("spurious_word", 32'(exp_q.size()), 32'd1);
      else check("word", 32'(out_data), 32'(exp_q.pop_front()));
      if (words == 0) first_word_edge = edge_n;
      last_word_edge = edge_n;
      words++;
    end
    if (done === 1'b1) begin
      if (done_cnt == 0) done_edge = edge_n;
      done_cnt++;
      check("done_after_last_word", 32'(exp_q.size()), 32'd0);
      if (loop_mode && start === 1'b1) begin
        passes++;
        for (int i = 0; i < int'(cur_len); i++) exp_q.push_back(mem_model[16'(cur_base + 16'(i))]);
      end
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic begin_scan(input logic [15:0] b, input logic [15:0] c);
    cur_base = b;
    cur_len  = c;
    done_cnt = 0;
    done_edge = -1;
    words = 0;
    first_valid_edge = -1;
    addr_log.delete();
    we_bad = 1'b0;
    for (int i = 0; i < int'(c); i++) exp_q.push_back(mem_model[16'(b + 16'(i))]);
    base_addr = b;
    count     = c;
    start     = 1'b1;
    cyc();
    start    = 1'b0;
    acc_edge = edge_n;
    passes   = 1;
  endtask

  task automatic wait_idle(input int budget, input bit rand_ready, input bit inject);
    bit fin = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
      if (inject && i == 2) begin
        start = 1'b1;
        base_addr = 16'h7777;
        count = 16'd3;
      end
      if (inject && i == 3) start = 1'b0;
      cyc();
      if (busy === 1'b0) begin
        fin = 1'b1;
        break;
      end
    end
    check("scan_finished_in_budget", 32'(fin), 32'd1);
  endtask

  task automatic end_scan_checks(input string tag);
    check({tag, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_done_once"}, 32'(done_cnt), 32'd1);
    check({tag, "_we_b_data_b_zero"}, 32'(we_bad), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem_model[i] = 16'($urandom);
    mem_model[16'h0010] = 16'hAAAA;
    mem_model[16'h0011] = 16'hBBBB;
    mem_model[16'h0012] = 16'hCCCC;
    mem_model[16'h0013] = 16'hDDDD;

    // Reset state
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_addr_b", 32'(addr_b), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_we_b", 32'(we_b), 32'd0);
    check("rst_data_b", 32'(data_b), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Basic scan A,B,C,D with consumer always ready
    out_ready = 1'b1;
    begin_scan(16'h0010, 16'd4);
    wait_idle(40, 1'b0, 1'b0);
    check("basic_first_valid_latency", 32'(first_valid_edge - acc_edge), 32'd2);
    check("basic_words", 32'(words), 32'd4);
    check("basic_back_to_back", 32'(last_word_edge - first_word_edge), 32'd3);
    end_scan_checks("basic");

    // Zero count: immediate done, no reads, no data
    begin_scan(16'h0200, 16'd0);
    wait_idle(10, 1'b0, 1'b0);
    check("zero_done_next_cycle", 32'(done_edge - acc_edge), 32'd0);
    check("zero_addr_unchanged", 32'(addr_log.size()), 32'd0);
    check("zero_no_valid", 32'(first_valid_edge), 32'hFFFF_FFFF);
    end_scan_checks("zero");

    // Address wrap through FFFF
    begin_scan(16'hFFFE, 16'd4);
    wait_idle(40, 1'b0, 1'b0);
    check("wrap_addr_changes", 32'(addr_log.size()), 32'd5);
    for (int i = 0; i < 5 && i < addr_log.size(); i++)
      check("wrap_addr_seq", 32'(addr_log[i]), 32'(16'(16'hFFFE + 16'(i))));
    end_scan_checks("wrap");

    // Back-pressure: FIFO fills, address stalls, nothing lost
    out_ready = 1'b0;
    begin_scan(16'h0010, 16'd8);
    repeat (10) cyc();
    check("stall_no_words", 32'(words), 32'd0);
    check("stall_out_valid", 32'(out_valid), 32'd1);
    check("stall_addr_held", 32'(addr_b), 32'(16'(16'h0010 + 16'(DEPTH))));
    out_ready = 1'b1;
    wait_idle(60, 1'b0, 1'b0);
    check("stall_words", 32'(words), 32'd8);
    end_scan_checks("stall");

    // Start pulsed while busy is ignored; random consumer
    begin_scan(16'h0400, 16'd6);
    wait_idle(200, 1'b1, 1'b1);
    check("busy_start_words", 32'(words), 32'd6);
    end_scan_checks("busy_start");

    // Random scans with random back-pressure
    for (int s = 0; s < 4; s++) begin
      begin_scan(16'($urandom), 16'($urandom_range(1, 12)));
      wait_idle(300, 1'b1, 1'b0);
      check("rand_words", 32'(words), 32'(cur_len));
      end_scan_checks("rand");
    end

    // Reset mid-scan after two accepted words
    out_ready = 1'b1;
    begin_scan(16'h0100, 16'd10);
    for (int i = 0; i < 20 && words < 2; i++) cyc();
    check("abort_two_words", 32'(words), 32'd2);
    #2 reset = 1'b0;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_addr_b", 32'(addr_b), 32'd0);
    check("abort_out_data", 32'(out_data), 32'd0);
    exp_q.delete();
    #3 reset = 1'b1;
    @(posedge clk);
    #1;
    edge_n++;
    done_cnt = 0;
    repeat (5) cyc();
    check("abort_no_done", 32'(done_cnt), 32'd0);
    check("abort_still_empty", 32'(out_valid), 32'd0);
    begin_scan(16'h0100, 16'd10);
    wait_idle(60, 1'b0, 1'b0);
    check("after_abort_words", 32'(words), 32'd10);
    end_scan_checks("after_abort");

`ifdef SCAN_LOOP_EN
    // Looping scan while start stays high
    loop_mode = 1'b1;
    begin_scan(16'h0010, 16'd2);
    start = 1'b1;
    for (int i = 0; i < 60 && passes < 3; i++) cyc();
    start = 1'b0;
    wait_idle(60, 1'b0, 1'b0);
    check("loop_passes", 32'(passes >= 3), 32'd1);
    check("loop_queue_drained", 32'(exp_q.size()), 32'd0);
    check("loop_done_per_pass", 32'(done_cnt), 32'(passes));
    check("loop_words", 32'(words), 32'(2 * passes));
    loop_mode = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
